// File: rtl/snitch_shared_muldiv_pkg.sv
// Shared definitions for the shared mul/div request arbiter.
// The request and response records depend on the block's width parameters.
// They are therefore declared inside the top module, built from the widths
// defined here.
package snitch_shared_muldiv_pkg;

  localparam int unsigned AddrWidth  = 32;
  localparam int unsigned InstrWidth = 32;

  // Width of the port index prepended to the transaction ID (at least one bit).
  function automatic int unsigned port_idx_width(input int unsigned nr_ports);
    return (nr_ports > 32'd1) ? $clog2(nr_ports) : 32'd1;
  endfunction

  // Width of a per-port outstanding counter able to hold 0..max_out.
  function automatic int unsigned cnt_width(input int unsigned max_out);
    return (max_out > 32'd0) ? $clog2(max_out + 32'd1) : 32'd1;
  endfunction

endpackage

// File: rtl/snitch_shared_muldiv_arb_chk.sv
// Run-time checks for the shared mul/div arbiter: response routing and counter range.
module snitch_shared_muldiv_arb_chk #(
  parameter int unsigned NrPorts        = 4,
  parameter int unsigned CntWidth       = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input logic                              clk_i,
  input logic                              rst_ni,
  input logic                              resp_misrouted_i,
  input logic [NrPorts-1:0]                underflow_i,
  input logic [NrPorts-1:0][CntWidth-1:0]  cnt_i
);

  // A response carrying a port index that does not exist is dropped.
  a_resp_idx_valid: assert property (@(posedge clk_i) disable iff (!rst_ni) !resp_misrouted_i);

  for (genvar i = 0; i < NrPorts; i++) begin : gen_port_chk
    // A response handshake must never find an empty counter.
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !underflow_i[i]);
    // A counter must never exceed the outstanding limit.
    a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  32'(cnt_i[i]) <= MaxOutstanding);
  end

endmodule

// File: rtl/snitch_shared_muldiv_rr_arb.sv
// Round-robin grant over an eligibility mask. The pointer moves past the
// served port only when the grant is actually taken.
module snitch_shared_muldiv_rr_arb
  import snitch_shared_muldiv_pkg::*;
#(
  parameter int unsigned NrPorts = 4,
  localparam int unsigned IdxWidth = port_idx_width(NrPorts)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NrPorts-1:0]  eligible_i,
  input  logic                advance_i,
  output logic [NrPorts-1:0]  gnt_o,
  output logic [IdxWidth-1:0] gnt_idx_o,
  output logic                gnt_valid_o
);

  logic [IdxWidth-1:0] ptr_r;
  logic [IdxWidth-1:0] idx_s;
  logic                found_s;

  // Search from the pointer onwards, wrapping once, for the first eligible port.
  always_comb begin
    int unsigned sum_s;
    int unsigned cand_s;
    logic        hit_s;
    sum_s   = 32'd0;
    cand_s  = 32'd0;
    hit_s   = 1'b0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int unsigned off = 0; off < NrPorts; off++) begin
      sum_s   = 32'(ptr_r) + off;
      cand_s  = (sum_s >= NrPorts) ? (sum_s - NrPorts) : sum_s;
      hit_s   = !found_s && eligible_i[IdxWidth'(cand_s)];
      idx_s   = hit_s ? IdxWidth'(cand_s) : idx_s;
      found_s = found_s || hit_s;
    end
  end

  // Present the winner as both an index and a one-hot vector.
  always_comb begin
    gnt_o        = '0;
    gnt_o[idx_s] = found_s;
    gnt_idx_o    = idx_s;
    gnt_valid_o  = found_s;
  end

  // Move the pointer to the port after the one just served.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_r <= '0;
    end else if (advance_i && found_s) begin
      if (idx_s == IdxWidth'(NrPorts - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= idx_s + IdxWidth'(1);
      end
    end
  end

endmodule

// File: rtl/snitch_shared_muldiv_arb.sv
// Request arbiter and response router letting NrPorts cores share one mul/div unit.
module snitch_shared_muldiv_arb
  import snitch_shared_muldiv_pkg::*;
#(
  parameter int unsigned NrPorts        = 4,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned PortIdxWidth  = port_idx_width(NrPorts),
  localparam int unsigned OutIdWidth    = IdWidth + PortIdxWidth
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NrPorts-1:0][AddrWidth-1:0]    core_qaddr_i,
  input  logic [NrPorts-1:0][IdWidth-1:0]      core_qid_i,
  input  logic [NrPorts-1:0][InstrWidth-1:0]   core_qdata_op_i,
  input  logic [NrPorts-1:0][DataWidth-1:0]    core_qdata_arga_i,
  input  logic [NrPorts-1:0][DataWidth-1:0]    core_qdata_argb_i,
  input  logic [NrPorts-1:0][DataWidth-1:0]    core_qdata_argc_i,
  input  logic [NrPorts-1:0]                   core_qvalid_i,
  output logic [NrPorts-1:0]                   core_qready_o,
  output logic [NrPorts-1:0][DataWidth-1:0]    core_pdata_o,
  output logic [NrPorts-1:0][IdWidth-1:0]      core_pid_o,
  output logic [NrPorts-1:0]                   core_perror_o,
  output logic [NrPorts-1:0]                   core_pvalid_o,
  input  logic [NrPorts-1:0]                   core_pready_i,
  output logic [AddrWidth-1:0]                 acc_qaddr_o,
  output logic [OutIdWidth-1:0]                acc_qid_o,
  output logic [InstrWidth-1:0]                acc_qdata_op_o,
  output logic [DataWidth-1:0]                 acc_qdata_arga_o,
  output logic [DataWidth-1:0]                 acc_qdata_argb_o,
  output logic [DataWidth-1:0]                 acc_qdata_argc_o,
  output logic                                 acc_qvalid_o,
  input  logic                                 acc_qready_i,
  input  logic [DataWidth-1:0]                 acc_pdata_i,
  input  logic [OutIdWidth-1:0]                acc_pid_i,
  input  logic                                 acc_perror_i,
  input  logic                                 acc_pvalid_i,
  output logic                                 acc_pready_o
);

  localparam int unsigned CntWidth = cnt_width(MaxOutstanding);

  typedef struct packed {
    logic [AddrWidth-1:0]  addr;
    logic [InstrWidth-1:0] op;
    logic [DataWidth-1:0]  arga;
    logic [DataWidth-1:0]  argb;
    logic [DataWidth-1:0]  argc;
    logic [OutIdWidth-1:0] id;
  } acc_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [IdWidth-1:0]   id;
    logic                 error;
  } core_rsp_t;

  acc_req_t                          req_r;
  acc_req_t                          sel_req_s;
  logic                              req_valid_r;
  logic                              stage_free_s;
  logic                              take_s;
  logic [NrPorts-1:0]                eligible_s;
  logic [NrPorts-1:0]                gnt_s;
  logic [PortIdxWidth-1:0]           gnt_idx_s;
  logic                              gnt_valid_s;
  logic [NrPorts-1:0]                inc_s;
  logic [NrPorts-1:0]                dec_s;
  logic [NrPorts-1:0]                underflow_s;
  logic [NrPorts-1:0][CntWidth-1:0]  cnt_s;
  logic [PortIdxWidth-1:0]           resp_idx_s;
  logic                              resp_idx_ok_s;
  logic [NrPorts-1:0]                resp_sel_s;
  core_rsp_t                         rsp_s;

  // The register can take a new request when empty or when it is being drained.
  assign stage_free_s = !req_valid_r || acc_qready_i;
  assign take_s       = stage_free_s && gnt_valid_s;
  assign core_qready_o = gnt_s & {NrPorts{stage_free_s}};

  snitch_shared_muldiv_rr_arb #(
    .NrPorts (NrPorts)
  ) i_rr_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .eligible_i  (eligible_s),
    .advance_i   (stage_free_s),
    .gnt_o       (gnt_s),
    .gnt_idx_o   (gnt_idx_s),
    .gnt_valid_o (gnt_valid_s)
  );

  // Gather the granted port's fields and tag its ID with the port index.
  always_comb begin
    sel_req_s      = '0;
    sel_req_s.addr = core_qaddr_i[gnt_idx_s];
    sel_req_s.op   = core_qdata_op_i[gnt_idx_s];
    sel_req_s.arga = core_qdata_arga_i[gnt_idx_s];
    sel_req_s.argb = core_qdata_argb_i[gnt_idx_s];
    sel_req_s.argc = core_qdata_argc_i[gnt_idx_s];
    sel_req_s.id   = {gnt_idx_s, core_qid_i[gnt_idx_s]};
  end

  // Output request register: load on grant, empty after acceptance, hold while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_r       <= '0;
      req_valid_r <= 1'b0;
    end else if (take_s) begin
      req_r       <= sel_req_s;
      req_valid_r <= 1'b1;
    end else if (acc_qready_i) begin
      req_valid_r <= 1'b0;
    end
  end

  assign acc_qaddr_o      = req_r.addr;
  assign acc_qid_o        = req_r.id;
  assign acc_qdata_op_o   = req_r.op;
  assign acc_qdata_arga_o = req_r.arga;
  assign acc_qdata_argb_o = req_r.argb;
  assign acc_qdata_argc_o = req_r.argc;
  assign acc_qvalid_o     = req_valid_r;

  // Response routing: the upper ID bits name the issuing port.
  assign resp_idx_s    = acc_pid_i[OutIdWidth-1:IdWidth];
  assign resp_idx_ok_s = (32'(resp_idx_s) < NrPorts);
  assign rsp_s         = '{data: acc_pdata_i, id: acc_pid_i[IdWidth-1:0], error: acc_perror_i};
  // An out-of-range index is accepted and dropped so the unit cannot deadlock.
  assign acc_pready_o  = resp_idx_ok_s ? |(core_pready_i & resp_sel_s) : 1'b1;

  for (genvar i = 0; i < NrPorts; i++) begin : gen_port
    logic [CntWidth-1:0] cnt_r;

    assign resp_sel_s[i]    = (resp_idx_s == PortIdxWidth'(i));
    assign core_pvalid_o[i] = acc_pvalid_i && resp_idx_ok_s && resp_sel_s[i];
    assign core_pdata_o[i]  = rsp_s.data;
    assign core_pid_o[i]    = rsp_s.id;
    assign core_perror_o[i] = rsp_s.error;

    assign eligible_s[i]  = core_qvalid_i[i] && (32'(cnt_r) < MaxOutstanding);
    assign inc_s[i]       = core_qvalid_i[i] && core_qready_o[i];
    assign dec_s[i]       = core_pvalid_o[i] && core_pready_i[i];
    assign underflow_s[i] = dec_s[i] && !inc_s[i] && (cnt_r == '0);
    assign cnt_s[i]       = cnt_r;

    // Count this port's requests that are in flight downstream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_r <= '0;
      end else begin
        case ({inc_s[i], dec_s[i]})
          2'b10:   cnt_r <= cnt_r + CntWidth'(1);
          2'b01:   cnt_r <= (cnt_r != '0) ? (cnt_r - CntWidth'(1)) : cnt_r;
          default: cnt_r <= cnt_r;
        endcase
      end
    end
  end

  snitch_shared_muldiv_arb_chk #(
    .NrPorts        (NrPorts),
    .CntWidth       (CntWidth),
    .MaxOutstanding (MaxOutstanding)
  ) i_chk (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .resp_misrouted_i (acc_pvalid_i && !resp_idx_ok_s),
    .underflow_i      (underflow_s),
    .cnt_i            (cnt_s)
  );

endmodule

// File: tb/tb_snitch_shared_muldiv_arb.sv
// Scoreboard bench for the shared mul/div arbiter: directed stimulus pushes
// expected downstream requests and core responses; a monitor checks every handshake.
module tb_snitch_shared_muldiv_arb;

  localparam int NP = 4;
  localparam int IW = 5;
  localparam int DW = 32;
  localparam int PW = 2;
  localparam int OW = IW + PW;

  typedef struct packed {
    logic [31:0]   addr;
    logic [31:0]   op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [OW-1:0] id;
  } req_t;

  typedef struct packed {
    logic [NP-1:0] pvalid;
    logic [DW-1:0] data;
    logic [IW-1:0] pid;
    logic          err;
  } rsp_t;

  logic                     clk_i;
  logic                     rst_ni;
  logic [NP-1:0][31:0]      core_qaddr;
  logic [NP-1:0][IW-1:0]    core_qid;
  logic [NP-1:0][31:0]      core_qdata_op;
  logic [NP-1:0][DW-1:0]    core_arga, core_argb, core_argc;
  logic [NP-1:0]            core_qvalid;
  logic [NP-1:0]            core_qready;
  logic [NP-1:0][DW-1:0]    core_pdata;
  logic [NP-1:0][IW-1:0]    core_pid;
  logic [NP-1:0]            core_perror;
  logic [NP-1:0]            core_pvalid;
  logic [NP-1:0]            core_pready;
  logic [31:0]              acc_qaddr, acc_qdata_op;
  logic [OW-1:0]            acc_qid;
  logic [DW-1:0]            acc_arga, acc_argb, acc_argc;
  logic                     acc_qvalid, acc_qready;
  logic [DW-1:0]            acc_pdata;
  logic [OW-1:0]            acc_pid;
  logic                     acc_perror, acc_pvalid, acc_pready;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   grants [NP];
  req_t exp_req_q [$];
  rsp_t exp_rsp_q [$];

  snitch_shared_muldiv_arb #(
    .NrPorts(NP), .IdWidth(IW), .DataWidth(DW), .MaxOutstanding(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_qaddr_i(core_qaddr), .core_qid_i(core_qid), .core_qdata_op_i(core_qdata_op),
    .core_qdata_arga_i(core_arga), .core_qdata_argb_i(core_argb), .core_qdata_argc_i(core_argc),
    .core_qvalid_i(core_qvalid), .core_qready_o(core_qready),
    .core_pdata_o(core_pdata), .core_pid_o(core_pid), .core_perror_o(core_perror),
    .core_pvalid_o(core_pvalid), .core_pready_i(core_pready),
    .acc_qaddr_o(acc_qaddr), .acc_qid_o(acc_qid), .acc_qdata_op_o(acc_qdata_op),
    .acc_qdata_arga_o(acc_arga), .acc_qdata_argb_o(acc_argb), .acc_qdata_argc_o(acc_argc),
    .acc_qvalid_o(acc_qvalid), .acc_qready_i(acc_qready),
    .acc_pdata_i(acc_pdata), .acc_pid_i(acc_pid), .acc_perror_i(acc_perror),
    .acc_pvalid_i(acc_pvalid), .acc_pready_o(acc_pready)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_req(input int p);
    req_t r;
    r.addr = core_qaddr[p];
    r.op   = core_qdata_op[p];
    r.a    = core_arga[p];
    r.b    = core_argb[p];
    r.c    = core_argc[p];
    r.id   = {PW'(p), core_qid[p]};
    exp_req_q.push_back(r);
  endtask

  task automatic push_rsp(input logic [NP-1:0] pv, input logic [DW-1:0] d,
                          input logic [IW-1:0] pid, input logic err);
    rsp_t r;
    r.pvalid = pv;
    r.data   = d;
    r.pid    = pid;
    r.err    = err;
    exp_rsp_q.push_back(r);
  endtask

  task automatic send_rsp(input int p, input logic [IW-1:0] qid, input logic [DW-1:0] d,
                          input logic err);
    acc_pvalid = 1'b1;
    acc_pid    = {PW'(p), qid};
    acc_pdata  = d;
    acc_perror = err;
    push_rsp(NP'(1 << p), d, qid, err);
  endtask

  // Monitor: every downstream request and core response handshake is scored.
  always @(negedge clk_i) begin
    req_t er;
    rsp_t rr;
    if (rst_ni) begin
      if (acc_qvalid && acc_qready) begin
        if (exp_req_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL acc_req_unexpected: got id %0h expected none", acc_qid);
        end else begin
          er = exp_req_q.pop_front();
          chk("acc_qid", 64'(acc_qid), 64'(er.id));
          chk("acc_qaddr", 64'(acc_qaddr), 64'(er.addr));
          chk("acc_qdata_op", 64'(acc_qdata_op), 64'(er.op));
          chk("acc_arga", 64'(acc_arga), 64'(er.a));
          chk("acc_argb", 64'(acc_argb), 64'(er.b));
          chk("acc_argc", 64'(acc_argc), 64'(er.c));
          grants[acc_qid[OW-1:IW]]++;
        end
      end
      if (acc_pvalid && acc_pready) begin
        if (exp_rsp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL core_rsp_unexpected: got pvalid %0h expected none", core_pvalid);
        end else begin
          rr = exp_rsp_q.pop_front();
          chk("core_pvalid", 64'(core_pvalid), 64'(rr.pvalid));
          for (int i = 0; i < NP; i++) begin
            chk("core_pdata", 64'(core_pdata[i]), 64'(rr.data));
            chk("core_pid", 64'(core_pid[i]), 64'(rr.pid));
            chk("core_perror", 64'(core_perror[i]), 64'(rr.err));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    core_qvalid = '0;
    core_pready = 4'hF;
    core_qid = '0;
    acc_qready = 1'b0;
    acc_pvalid = 1'b0;
    acc_pid = '0;
    acc_pdata = '0;
    acc_perror = 1'b0;
    for (int p = 0; p < NP; p++) begin
      grants[p]        = 0;
      core_qaddr[p]    = 32'h8000_0000 + 32'(p * 4);
      core_qdata_op[p] = (p % 2 == 0) ? 32'h02B5_0533 : 32'h02B5_4533;
      core_arga[p]     = 32'h0000_1100 + 32'(p);
      core_argb[p]     = 32'h0000_2200 + 32'(p);
      core_argc[p]     = 32'h0000_3300 + 32'(p);
    end

    // Reset state
    @(negedge clk_i);
    chk("rst_acc_qvalid", 64'(acc_qvalid), 64'd0);
    chk("rst_acc_qid", 64'(acc_qid), 64'd0);
    chk("rst_acc_qaddr", 64'(acc_qaddr), 64'd0);
    chk("rst_acc_arga", 64'(acc_arga), 64'd0);
    chk("rst_core_pvalid", 64'(core_pvalid), 64'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    nxt();

    // Single port: port 2, id 3
    acc_qready = 1'b1;
    core_qid[2] = 5'd3;
    core_qvalid[2] = 1'b1;
    push_req(2);
    @(negedge clk_i);
    chk("single_qready", 64'(core_qready), 64'b0100);
    chk("single_qvalid_lat0", 64'(acc_qvalid), 64'd0);
    nxt();
    core_qvalid[2] = 1'b0;
    @(negedge clk_i);
    chk("single_qvalid_lat1", 64'(acc_qvalid), 64'd1);
    chk("single_qid", 64'(acc_qid), 64'h43);
    nxt();
    send_rsp(2, 5'd3, 32'h2A, 1'b0);
    @(negedge clk_i);
    chk("single_pready", 64'(acc_pready), 64'd1);
    chk("single_pvalid", 64'(core_pvalid), 64'b0100);
    chk("single_idle", 64'(acc_qvalid), 64'd0);
    nxt();
    acc_pvalid = 1'b0;

    // Fairness: all four ports request; pointer sits at 3 after the grant to port 2
    for (int p = 0; p < NP; p++) begin
      core_qid[p] = 5'(8 + p);
      grants[p] = 0;
    end
    core_qvalid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      push_req((3 + k) % NP);
      @(negedge clk_i);
      chk("fair_qready", 64'(core_qready), 64'(1 << ((3 + k) % NP)));
      nxt();
    end
    @(negedge clk_i);
    chk("limit_all_masked", 64'(core_qready), 64'd0);
    nxt();
    core_qvalid = '0;
    for (int p = 0; p < NP; p++) chk("fair_share", 64'(grants[p]), 64'd2);
    for (int k = 0; k < 8; k++) begin
      send_rsp((3 + k) % NP, 5'(8 + (3 + k) % NP), 32'h1000 + 32'(k), k == 5);
      nxt();
    end
    acc_pvalid = 1'b0;

    // Backpressure: three ports request while the unit stalls
    acc_qready = 1'b0;
    core_qid[0] = 5'd10;
    core_qid[1] = 5'd11;
    core_qid[3] = 5'd13;
    core_qvalid = 4'b1011;
    push_req(3);
    @(negedge clk_i);
    chk("bp_first_gnt", 64'(core_qready), 64'b1000);
    nxt();
    core_qvalid[3] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("bp_qready", 64'(core_qready), 64'd0);
      chk("bp_qvalid", 64'(acc_qvalid), 64'd1);
      chk("bp_qid", 64'(acc_qid), 64'h6D);
      chk("bp_qaddr", 64'(acc_qaddr), 64'(core_qaddr[3]));
      nxt();
    end
    acc_qready = 1'b1;
    push_req(0);
    @(negedge clk_i);
    chk("bp_resume_ptr", 64'(core_qready), 64'b0001);
    nxt();
    core_qvalid[0] = 1'b0;
    push_req(1);
    @(negedge clk_i);
    chk("bp_next", 64'(core_qready), 64'b0010);
    nxt();
    core_qvalid[1] = 1'b0;
    @(negedge clk_i);
    chk("bp_last_valid", 64'(acc_qvalid), 64'd1);
    nxt();

    // Response backpressure on port 1
    acc_pvalid = 1'b1;
    acc_pid = {2'd1, 5'd11};
    acc_pdata = 32'hBEEF;
    acc_perror = 1'b0;
    core_pready = 4'b1101;
    @(negedge clk_i);
    chk("rbp_pready_low", 64'(acc_pready), 64'd0);
    chk("rbp_pvalid", 64'(core_pvalid), 64'b0010);
    nxt();
    @(negedge clk_i);
    chk("rbp_pready_hold", 64'(acc_pready), 64'd0);
    core_pready = 4'hF;
    push_rsp(4'b0010, 32'hBEEF, 5'd11, 1'b0);
    #1;
    chk("rbp_pready_high", 64'(acc_pready), 64'd1);
    nxt();
    send_rsp(3, 5'd13, 32'hCAFE, 1'b1);
    nxt();
    acc_pvalid = 1'b0;

    // Outstanding limit on port 0 (one request from the previous phase in flight)
    core_qid[0] = 5'd20;
    core_qvalid[0] = 1'b1;
    push_req(0);
    @(negedge clk_i);
    chk("lim_p0_second", 64'(core_qready), 64'b0001);
    nxt();
    core_qid[1] = 5'd21;
    core_qvalid[1] = 1'b1;
    push_req(1);
    @(negedge clk_i);
    chk("lim_p0_masked_p1", 64'(core_qready), 64'b0010);
    nxt();
    core_qvalid[1] = 1'b0;
    send_rsp(0, 5'd10, 32'hA0, 1'b0);
    @(negedge clk_i);
    chk("lim_p0_masked", 64'(core_qready), 64'd0);
    nxt();
    send_rsp(0, 5'd20, 32'hA1, 1'b0);
    core_qid[0] = 5'd22;
    push_req(0);
    @(negedge clk_i);
    chk("lim_regrant", 64'(core_qready), 64'b0001);
    nxt();
    acc_pvalid = 1'b0;
    core_qid[0] = 5'd23;
    push_req(0);
    @(negedge clk_i);
    chk("lim_simul_keeps", 64'(core_qready), 64'b0001);
    nxt();
    @(negedge clk_i);
    chk("lim_full_again", 64'(core_qready), 64'd0);
    nxt();
    core_qvalid[0] = 1'b0;
    send_rsp(0, 5'd22, 32'hA2, 1'b0);
    nxt();
    send_rsp(0, 5'd23, 32'hA3, 1'b0);
    nxt();
    send_rsp(1, 5'd21, 32'hA4, 1'b0);
    nxt();
    acc_pvalid = 1'b0;

    // Reset while a request is stalled and a counter is nonzero
    acc_qready = 1'b0;
    core_qid[2] = 5'd7;
    core_qvalid[2] = 1'b1;
    @(negedge clk_i);
    chk("rst_pre_gnt", 64'(core_qready), 64'b0100);
    nxt();
    core_qvalid[2] = 1'b0;
    @(negedge clk_i);
    chk("rst_pre_valid", 64'(acc_qvalid), 64'd1);
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_mid_qvalid", 64'(acc_qvalid), 64'd0);
    chk("rst_mid_qid", 64'(acc_qid), 64'd0);
    nxt();
    nxt();
    rst_ni = 1'b1;
    acc_qready = 1'b1;
    for (int p = 0; p < NP; p++) core_qid[p] = 5'(24 + p);
    core_qvalid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      push_req(k % NP);
      @(negedge clk_i);
      chk("rst_rr_order", 64'(core_qready), 64'(1 << (k % NP)));
      nxt();
    end
    core_qvalid = '0;
    @(negedge clk_i);
    nxt();
    chk("end_req_queue", 64'(exp_req_q.size()), 64'd0);
    chk("end_rsp_queue", 64'(exp_rsp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
